sdf_stage_4: RTL and testbench
==============================

SDF_STAGE_4 -- requirements
Module: sdf_stage_4

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  din_r/din_i, w_r/w_i and state are valid this cycle; the stage advances only on these cycles.
REQ-005 din_r, din_i  input  24  signed sample, two's complement, 8 fractional bits (1.0 = 0x000100).
REQ-006 w_r, w_i  input  24  signed twiddle, same format, from the companion stage-4 twiddle ROM; sampled in the same cycle (combinational source).
REQ-007 state  input  2  phase from the twiddle ROM: 0 = fill, 1 = butterfly, 2 = twiddle-multiply, 3 = illegal.
REQ-008 dout_r, dout_i  output  24  registered result, same format.
REQ-009 out_valid  output  1  dout is valid this cycle.
REQ-010 err  output  1  sticky flag: state==3 was seen with in_valid=1.

Function
REQ-011 The block SHALL hold a 4-entry complex delay line D[0..3] (24+24 bits each); a shift writes D[0], moves D[k] to D[k+1], and D[3] is the oldest entry.
REQ-012 When in_valid=1 and state=0, it SHALL shift din into D and drive out_valid=0 on the next cycle.
REQ-013 When in_valid=1 and state=1, it SHALL register dout = D[3] + din, shift in D[3] - din, and drive out_valid=1 on the next cycle.
REQ-014 When in_valid=1 and state=2, it SHALL register dout = D[3] x (w_r + j*w_i), shift in din, and drive out_valid=1 on the next cycle.
REQ-015 Add and subtract SHALL be 24-bit two's-complement with wrap-around; no saturation.
REQ-016 The complex multiply SHALL work as follows:
- real = ar*wr - ai*wi and imag = ar*wi + ai*wr;
- each is computed at full 48-bit signed width;
- the result is bits [31:8] (arithmetic truncation, no rounding).
REQ-017 Latency SHALL be exactly 1 cycle from the in_valid sample to the out_valid/dout cycle.
REQ-018 When in_valid=0, D, dout and err SHALL hold, and out_valid SHALL be 0 on the next cycle (stall; no bubbles inserted into D).
REQ-019 When in_valid=1 and state=3, it SHALL set err, leave D and dout unchanged, and drive out_valid=0.
REQ-020 err SHALL clear only on reset.
REQ-021 The block SHALL NOT check the state sequence beyond REQ-019; phase ordering is the ROM's responsibility.

Reset
REQ-022 While rst_n=0, all outputs SHALL be 0: dout_r, dout_i, out_valid and err.
REQ-023 While rst_n=0, all D entries SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL discard the delay-line contents.
REQ-025 After reset release, the first in_valid cycle SHALL be processed per the state supplied.

Structure
REQ-026 A shared package SHALL hold the data width (24), the fraction bits (8), the delay depth (4) and the state encodings FILL=0, BFLY=1, TWID=2.
REQ-027 The complex multiplier SHALL be a sub-module, cmult_q8, which is combinational and reusable by the other stages.
REQ-028 The delay line, the butterfly and the output registers SHALL reside in sdf_stage_4.

Verification
REQ-029 Impulse: 12 valid cycles, din_r = 0x000100 on sample 0 and 0 elsewhere, state 0x4, 1x4, 2x4, ROM twiddles.
- Expected dout_r: 0x100, 0, 0, 0, 0x100, 0, 0, 0.
- dout_i = 0 throughout; out_valid on 8 cycles.
REQ-030 DC: din_r = 0x000100 on all 12 samples, same state sequence.
- Expected dout_r: 0x200 x4, then 0 x4.
REQ-031 Twiddle W1: din_r = 0x000100 on sample 1 only; state-2 cycle 2 with w = (0x0000B5, 0xFFFF4B).
- Expected dout = (0x0000B5, 0xFFFF4B).
REQ-032 Stall: in_valid deasserted for 3 cycles in the middle of state 1.
- out_valid=0 for those 3 cycles.
- Resumed outputs are identical to the unstalled run.
REQ-033 Reset mid-frame: rst_n pulsed low during state 2.
- Outputs and D go to 0 immediately.
- A fresh frame then reproduces the REQ-029 results.
REQ-034 Illegal state: in_valid=1 with state=3.
- err=1 next cycle and stays 1 until reset.
- out_valid=0 and dout unchanged.

Source files
------------

// File: rtl/sdf_stage_4_pkg.sv
// sdf_stage_4_pkg: shared widths, delay depth and twiddle-ROM phase encodings for the SDF stages
package sdf_stage_4_pkg;
  localparam int DW    = 24;
  localparam int FB    = 8;
  localparam int DEPTH = 4;
  typedef enum logic [1:0] {FILL = 2'd0, BFLY = 2'd1, TWID = 2'd2, ILL = 2'd3} state_e;
endpackage

// File: rtl/cmult_q8.sv
// cmult_q8: combinational Q.8 complex multiply, p = a * w, full-width products truncated to [31:8]
module cmult_q8
  import sdf_stage_4_pkg::*;
(
  input  logic [DW-1:0] ar_i,
  input  logic [DW-1:0] ai_i,
  input  logic [DW-1:0] wr_i,
  input  logic [DW-1:0] wi_i,
  output logic [DW-1:0] pr_o,
  output logic [DW-1:0] pi_o
);
  logic signed [2*DW-1:0] ar, ai, wr, wi, re, im;
  assign ar = {{DW{ar_i[DW-1]}}, ar_i};
  assign ai = {{DW{ai_i[DW-1]}}, ai_i};
  assign wr = {{DW{wr_i[DW-1]}}, wr_i};
  assign wi = {{DW{wi_i[DW-1]}}, wi_i};
  assign re = ar * wr - ai * wi;
  assign im = ar * wi + ai * wr;
  assign pr_o = re[DW+FB-1:FB];
  assign pi_o = im[DW+FB-1:FB];
endmodule

// File: rtl/sdf_stage_4.sv
// sdf_stage_4: radix-2 SDF stage with a 4-deep complex delay line, butterfly and twiddle multiply
module sdf_stage_4
  import sdf_stage_4_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  input  logic [1:0]    state,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          out_valid,
  output logic          err
);
  logic [DW-1:0] dr_q [DEPTH];
  logic [DW-1:0] di_q [DEPTH];
  logic [DW-1:0] dout_r_q, dout_i_q, dout_r_d, dout_i_d, sr_d, si_d, pr, pi;
  logic          out_valid_q, err_q, bfly, twid, ill, shift;
  state_e        st;
  assign st    = state_e'(state);
  assign bfly  = in_valid && st == BFLY;
  assign twid  = in_valid && st == TWID;
  assign ill   = in_valid && st == ILL;
  assign shift = in_valid && st != ILL;
  cmult_q8 u_cmult (
    .ar_i(dr_q[DEPTH-1]),
    .ai_i(di_q[DEPTH-1]),
    .wr_i(w_r),
    .wi_i(w_i),
    .pr_o(pr),
    .pi_o(pi)
  );
  always_comb begin
    sr_d     = bfly ? dr_q[DEPTH-1] - din_r : din_r;
    si_d     = bfly ? di_q[DEPTH-1] - din_i : din_i;
    dout_r_d = bfly ? dr_q[DEPTH-1] + din_r : twid ? pr : dout_r_q;
    dout_i_d = bfly ? di_q[DEPTH-1] + din_i : twid ? pi : dout_i_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        dr_q[k] <= '0;
        di_q[k] <= '0;
      end
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (shift) begin
        dr_q[0] <= sr_d;
        di_q[0] <= si_d;
        for (int k = 1; k < DEPTH; k++) begin
          dr_q[k] <= dr_q[k-1];
          di_q[k] <= di_q[k-1];
        end
      end
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= bfly || twid;
      err_q       <= err_q || ill;
    end
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
endmodule

// File: tb/tb_sdf_stage_4.sv
// tb_sdf_stage_4: table-driven directed checks of sdf_stage_4 frames, stall, reset and illegal state
module tb_sdf_stage_4;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0]  state = '0;
  logic [23:0] dout_r, dout_i;
  logic        out_valid, err;
  int          checks = 0, errors = 0;
  logic        err_exp = 1'b0;
  logic [23:0] twr [4] = '{24'h000100, 24'h0000B5, 24'h000000, 24'hFFFF4B};
  logic [23:0] twi [4] = '{24'h000000, 24'hFFFF4B, 24'hFFFF00, 24'hFFFF4B};
  typedef struct {
    logic        v;
    logic [23:0] dr, di, wr, wi;
    logic [1:0]  st;
    logic        ov, cd;
    logic [23:0] er, ei;
    logic        ee;
  } vec_t;
  vec_t tbl[$];
  sdf_stage_4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i), .state(state),
    .dout_r(dout_r), .dout_i(dout_i), .out_valid(out_valid), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask
  task automatic push(input logic v, input logic [23:0] dr, di, wr, wi, input logic [1:0] st,
                      input logic ov, cd, input logic [23:0] er, ei);
    vec_t t;
    t.v = v; t.dr = dr; t.di = di; t.wr = wr; t.wi = wi; t.st = st;
    t.ov = ov; t.cd = cd; t.er = er; t.ei = ei; t.ee = err_exp;
    tbl.push_back(t);
  endtask
  task automatic apply(input vec_t t, input string nm);
    in_valid = t.v; din_r = t.dr; din_i = t.di; w_r = t.wr; w_i = t.wi; state = t.st;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " out_valid"}, 24'(out_valid), 24'(t.ov));
    chk({nm, " err"}, 24'(err), 24'(t.ee));
    if (t.cd) begin
      chk({nm, " dout_r"}, dout_r, t.er);
      chk({nm, " dout_i"}, dout_i, t.ei);
    end
  endtask
  task automatic run(input string nm, input int n);
    for (int i = 0; i < n && i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
    in_valid = 1'b0;
  endtask
  task automatic add_frame(input logic [11:0][23:0] x, input logic [7:0][23:0] er, ei, input int stall_at);
    for (int k = 0; k < 12; k++) begin
      if (k == stall_at)
        for (int s = 0; s < 3; s++) push(1'b0, 24'h777, 24'h777, '0, '0, 2'd3, 1'b0, 1'b1, er[k-5], ei[k-5]);
      push(1'b1, x[k], '0, k >= 8 ? twr[k%4] : 24'h100, k >= 8 ? twi[k%4] : 24'h0, 2'(k / 4),
           k >= 4, k >= 4, k >= 4 ? er[k-4] : '0, k >= 4 ? ei[k-4] : '0);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " dout_r"}, dout_r, '0);
    chk({nm, " dout_i"}, dout_i, '0);
    chk({nm, " out_valid"}, 24'(out_valid), '0);
    chk({nm, " err"}, 24'(err), '0);
  endtask
  logic [11:0][23:0] x, x_imp;
  logic [7:0][23:0]  er, ei, er_imp, ei_imp;
  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    x_imp = '0; x_imp[0] = 24'h100;
    er_imp = '0; er_imp[0] = 24'h100; er_imp[4] = 24'h100;
    ei_imp = '0;
    add_frame(x_imp, er_imp, ei_imp, -1);
    run("impulse", 99);
    for (int k = 0; k < 12; k++) x[k] = 24'h100;
    er = '0; ei = '0;
    for (int k = 0; k < 4; k++) er[k] = 24'h200;
    add_frame(x, er, ei, -1);
    run("dc", 99);
    x = '0; x[1] = 24'h100;
    er = '0; er[1] = 24'h100; er[5] = 24'h0000B5;
    ei = '0; ei[5] = 24'hFFFF4B;
    add_frame(x, er, ei, -1);
    run("w1", 99);
    add_frame(x_imp, er_imp, ei_imp, 5);
    run("stall", 99);
    x = x_imp; x[8] = 24'h100; x[9] = 24'h100;
    add_frame(x, er_imp, ei_imp, -1);
    run("pre_rst", 9);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    chk_reset("mid_rst_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) push(1'b1, '0, '0, 24'h100, '0, 2'd1, 1'b1, 1'b1, '0, '0);
    run("d_cleared", 99);
    add_frame(x_imp, er_imp, ei_imp, -1);
    run("impulse2", 99);
    push(1'b1, 24'h123, 24'h45, 24'h100, '0, 2'd1, 1'b1, 1'b1, 24'h123, 24'h45);
    err_exp = 1'b1;
    push(1'b1, 24'h777, 24'h777, 24'h100, '0, 2'd3, 1'b0, 1'b1, 24'h123, 24'h45);
    for (int k = 0; k < 3; k++) push(1'b1, '0, '0, 24'h100, '0, 2'd0, 1'b0, 1'b1, 24'h123, 24'h45);
    push(1'b1, '0, '0, 24'h100, '0, 2'd1, 1'b1, 1'b1, 24'hFFFEDD, 24'hFFFFBB);
    run("illegal", 99);
    rst_n = 1'b0;
    #1;
    chk_reset("err_clear");
    @(negedge clk);
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
